// File: rtl/l2_wcb_param.sv
// Write-combining buffer between the L2 store path and the request-out channel.
// Define L2_WCB_TIMEOUT_EN to drain a lone below-threshold entry after 1023 idle cycles.
module l2_wcb_param #(
  parameter int N_ENTRIES      = 4,
  parameter int WORDS_PER_LINE = 4,
  parameter int WORD_BITS      = 64,
  parameter int LINE_ADDR_BITS = 28,
  parameter int DRAIN_THRESH   = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                wr_valid,
  output logic                                wr_ready,
  input  logic [LINE_ADDR_BITS-1:0]           wr_addr,
  input  logic [$clog2(WORDS_PER_LINE)-1:0]   wr_woff,
  input  logic [WORD_BITS-1:0]                wr_data,
  input  logic [LINE_ADDR_BITS-1:0]           lk_addr,
  output logic                                lk_hit,
  output logic [WORDS_PER_LINE*WORD_BITS-1:0] lk_line,
  output logic [WORDS_PER_LINE-1:0]           lk_mask,
  output logic                                dr_valid,
  input  logic                                dr_ready,
  output logic [LINE_ADDR_BITS-1:0]           dr_addr,
  output logic [WORDS_PER_LINE*WORD_BITS-1:0] dr_line,
  output logic [WORDS_PER_LINE-1:0]           dr_mask,
  input  logic                                fence_valid,
  output logic                                fence_ready,
  output logic [$clog2(N_ENTRIES):0]          count
);

  localparam int PTR_W  = $clog2(N_ENTRIES);
  localparam int CNT_W  = PTR_W + 1;
  localparam int LINE_W = WORDS_PER_LINE * WORD_BITS;

  typedef enum logic {ST_IDLE, ST_FENCE} state_e;

  state_e                    state_q;
  logic                      fence_ready_q;
  logic [N_ENTRIES-1:0]      vld_q;
  logic [LINE_ADDR_BITS-1:0] addr_q [N_ENTRIES];
  logic [LINE_W-1:0]         line_q [N_ENTRIES];
  logic [WORDS_PER_LINE-1:0] mask_q [N_ENTRIES];
  logic [PTR_W-1:0]          head_q, tail_q;
  logic [CNT_W-1:0]          count_q, count_d;
  logic                      dr_valid_q, dr_valid_d;

  logic                      wr_hit, lk_hit_c;
  logic [PTR_W-1:0]          wr_hit_idx, lk_idx;
  logic                      wr_ready_c, wr_fire, alloc, merge, dr_fire;
  logic                      drain_cond, timeout;
  logic [LINE_W-1:0]         alloc_line;
  logic [WORDS_PER_LINE-1:0] alloc_mask;

  // Address CAM for the write port and the lookup port; allocation keeps at most one match.
  always_comb begin
    wr_hit     = 1'b0;
    wr_hit_idx = '0;
    lk_hit_c   = 1'b0;
    lk_idx     = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (vld_q[i] && (addr_q[i] == wr_addr)) begin
        wr_hit     = 1'b1;
        wr_hit_idx = PTR_W'(i);
      end
      if (vld_q[i] && (addr_q[i] == lk_addr)) begin
        lk_hit_c = 1'b1;
        lk_idx   = PTR_W'(i);
      end
    end
  end

  always_comb begin
    if (state_q != ST_IDLE) begin
      wr_ready_c = 1'b0;
    end else if (wr_hit) begin
      wr_ready_c = !((wr_hit_idx == head_q) && dr_valid_q);
    end else begin
      wr_ready_c = (count_q < CNT_W'(N_ENTRIES));
    end
  end

  assign wr_fire = wr_valid && wr_ready_c;
  assign alloc   = wr_fire && !wr_hit;
  assign merge   = wr_fire && wr_hit;
  assign dr_fire = dr_valid_q && dr_ready;

  always_comb begin
    alloc_line = '0;
    alloc_line[int'(wr_woff)*WORD_BITS +: WORD_BITS] = wr_data;
    alloc_mask = '0;
    alloc_mask[wr_woff] = 1'b1;
  end

  always_comb begin
    count_d = count_q;
    if (alloc && !dr_fire) begin
      count_d = count_q + CNT_W'(1);
    end else if (!alloc && dr_fire) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  assign drain_cond = (count_q != '0) &&
                      ((count_q >= CNT_W'(DRAIN_THRESH)) || (state_q == ST_FENCE) || timeout);
  // Once presented the head stays locked until it is taken.
  assign dr_valid_d = dr_valid_q ? !dr_ready : drain_cond;

`ifdef L2_WCB_TIMEOUT_EN
  logic [9:0] idle_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_q <= '0;
    end else if (wr_fire || dr_fire) begin
      idle_q <= '0;
    end else if ((count_q != '0) && (idle_q != 10'd1023)) begin
      idle_q <= idle_q + 10'd1;
    end
  end

  assign timeout = (idle_q == 10'd1023);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      dr_valid_q <= 1'b0;
    end else begin
      if (alloc) begin
        vld_q[tail_q] <= 1'b1;
        tail_q        <= tail_q + PTR_W'(1);
      end
      if (dr_fire) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= head_q + PTR_W'(1);
      end
      count_q    <= count_d;
      dr_valid_q <= dr_valid_d;
    end
  end

  // Entry payload carries no reset; vld_q alone decides what is live.
  always_ff @(posedge clk) begin
    if (alloc) begin
      addr_q[tail_q] <= wr_addr;
      line_q[tail_q] <= alloc_line;
      mask_q[tail_q] <= alloc_mask;
    end
    if (merge) begin
      line_q[wr_hit_idx][int'(wr_woff)*WORD_BITS +: WORD_BITS] <= wr_data;
      mask_q[wr_hit_idx][wr_woff] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      fence_ready_q <= 1'b0;
    end else begin
      fence_ready_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (fence_valid) begin
            state_q <= ST_FENCE;
          end
        end
        ST_FENCE: begin
          if (count_q == '0) begin
            fence_ready_q <= 1'b1;
            state_q       <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign wr_ready    = wr_ready_c;
  assign lk_hit      = lk_hit_c;
  assign lk_line     = lk_hit_c ? line_q[lk_idx] : '0;
  assign lk_mask     = lk_hit_c ? mask_q[lk_idx] : '0;
  assign dr_valid    = dr_valid_q;
  assign dr_addr     = dr_valid_q ? addr_q[head_q] : '0;
  assign dr_line     = dr_valid_q ? line_q[head_q] : '0;
  assign dr_mask     = dr_valid_q ? mask_q[head_q] : '0;
  assign fence_ready = fence_ready_q;
  assign count       = count_q;

  a_count_bound: assert property (@(posedge clk) disable iff (!rst)
    count_q <= CNT_W'(N_ENTRIES));
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(alloc && !dr_fire && (count_q == CNT_W'(N_ENTRIES))));

endmodule

// File: tb/tb_l2_wcb_param.sv
// Bench for l2_wcb_param: directed scenarios plus randomized traffic against a queue model.
module tb_l2_wcb_param;
  localparam int N  = 4;
  localparam int WPL = 4;
  localparam int WB = 64;
  localparam int LA = 28;
  localparam int TH = 2;
  localparam int LW = WPL * WB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_valid, wr_ready;
  logic [LA-1:0] wr_addr;
  logic [1:0]    wr_woff;
  logic [WB-1:0] wr_data;
  logic [LA-1:0] lk_addr;
  logic          lk_hit;
  logic [LW-1:0] lk_line;
  logic [WPL-1:0] lk_mask;
  logic          dr_valid, dr_ready;
  logic [LA-1:0] dr_addr;
  logic [LW-1:0] dr_line;
  logic [WPL-1:0] dr_mask;
  logic          fence_valid, fence_ready;
  logic [2:0]    count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [LA-1:0]  addr;
    logic [LW-1:0]  line;
    logic [WPL-1:0] mask;
  } ent_t;
  ent_t mq[$];

  l2_wcb_param #(
    .N_ENTRIES(N), .WORDS_PER_LINE(WPL), .WORD_BITS(WB),
    .LINE_ADDR_BITS(LA), .DRAIN_THRESH(TH)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_woff(wr_woff), .wr_data(wr_data),
    .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_line(lk_line), .lk_mask(lk_mask),
    .dr_valid(dr_valid), .dr_ready(dr_ready), .dr_addr(dr_addr),
    .dr_line(dr_line), .dr_mask(dr_mask),
    .fence_valid(fence_valid), .fence_ready(fence_ready),
    .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle_inputs();
    wr_valid = 1'b0; wr_addr = '0; wr_woff = '0; wr_data = '0;
    lk_addr = '0; dr_ready = 1'b0; fence_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    mq.delete();
  endtask

  task automatic do_write(input logic [LA-1:0] a, input logic [1:0] o, input logic [WB-1:0] d);
    wr_addr = a; wr_woff = o; wr_data = d; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    #2 rst = 1'b0;
    #1;
    lk_addr = 28'h100;
    #1;
    total++; if (dr_valid !== 1'b0) begin bad++; $display("FAIL rst_dr_valid: got %b want 0", dr_valid); end
    total++; if (fence_ready !== 1'b0) begin bad++; $display("FAIL rst_fence_ready: got %b want 0", fence_ready); end
    total++; if (lk_hit !== 1'b0) begin bad++; $display("FAIL rst_lk_hit: got %b want 0", lk_hit); end
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL rst_wr_ready: got %b want 1", wr_ready); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", count); end
    total++; if ({dr_addr, dr_mask, lk_mask} !== '0 || dr_line !== '0 || lk_line !== '0) begin
      bad++; $display("FAIL rst_data_outs: got addr=%h mask=%h lkmask=%h want all zero", dr_addr, dr_mask, lk_mask);
    end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_merge();
    do_reset();
    do_write(28'h100, 2'd1, 64'hAA);
    lk_addr = 28'h100;
    #1;
    total++; if (count !== 3'd1) begin bad++; $display("FAIL merge_count: got %0d want 1", count); end
    total++; if (lk_hit !== 1'b1) begin bad++; $display("FAIL merge_lk_hit: got %b want 1", lk_hit); end
    total++; if (lk_mask !== 4'b0010) begin bad++; $display("FAIL merge_lk_mask: got %b want 0010", lk_mask); end
    total++; if (lk_line !== (LW'(64'hAA) << 64)) begin bad++; $display("FAIL merge_lk_line: got %h", lk_line); end
    repeat (5) tick();
    total++; if (dr_valid !== 1'b0) begin bad++; $display("FAIL merge_no_drain: got %b want 0", dr_valid); end
  endtask

  task automatic test_drain();
    do_reset();
    do_write(28'h100, 2'd1, 64'hAA);
    do_write(28'h100, 2'd3, 64'hBB);
    do_write(28'h200, 2'd0, 64'hCC);
    total++; if (count !== 3'd2) begin bad++; $display("FAIL drain_count2: got %0d want 2", count); end
    total++; if (dr_valid !== 1'b0) begin bad++; $display("FAIL drain_early: got %b want 0", dr_valid); end
    tick();
    total++; if (dr_valid !== 1'b1 || dr_addr !== 28'h100) begin
      bad++; $display("FAIL drain_present: got v=%b addr=%h want v=1 addr=100", dr_valid, dr_addr);
    end
    total++; if (dr_mask !== 4'b1010) begin bad++; $display("FAIL drain_mask: got %b want 1010", dr_mask); end
    total++; if (dr_line !== ((LW'(64'hBB) << 192) | (LW'(64'hAA) << 64))) begin
      bad++; $display("FAIL drain_line: got %h", dr_line);
    end
    dr_ready = 1'b1;
    tick();
    dr_ready = 1'b0;
    lk_addr = 28'h200;
    #1;
    total++; if (count !== 3'd1) begin bad++; $display("FAIL drain_count1: got %0d want 1", count); end
    total++; if (dr_valid !== 1'b0) begin bad++; $display("FAIL drain_bubble: got %b want 0", dr_valid); end
    total++; if (lk_hit !== 1'b1 || lk_mask !== 4'b0001) begin
      bad++; $display("FAIL drain_next_head: got hit=%b mask=%b want 1/0001", lk_hit, lk_mask);
    end
    lk_addr = 28'h100;
    #1;
    total++; if (lk_hit !== 1'b0) begin bad++; $display("FAIL drain_gone: got %b want 0", lk_hit); end
    repeat (4) tick();
    total++; if (dr_valid !== 1'b0) begin bad++; $display("FAIL drain_below_thresh: got %b want 0", dr_valid); end
  endtask

  task automatic test_full_stall();
    do_reset();
    for (int k = 0; k < 4; k++) do_write(28'h100 * LA'(k + 1), 2'(k), 64'(k + 1));
    total++; if (count !== 3'd4) begin bad++; $display("FAIL full_count: got %0d want 4", count); end
    wr_addr = 28'h500; wr_woff = 2'd0; wr_data = 64'h55; wr_valid = 1'b1;
    #1;
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL full_stall: got %b want 0", wr_ready); end
    tick();
    total++; if (wr_ready !== 1'b0 || dr_addr !== 28'h100) begin
      bad++; $display("FAIL full_hold: got rdy=%b addr=%h want 0/100", wr_ready, dr_addr);
    end
    dr_ready = 1'b1;
    #1;
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL full_hs_cycle: got %b want 0", wr_ready); end
    tick();
    dr_ready = 1'b0;
    #1;
    total++; if (wr_ready !== 1'b1 || count !== 3'd3) begin
      bad++; $display("FAIL full_after_hs: got rdy=%b count=%0d want 1/3", wr_ready, count);
    end
    tick();
    wr_valid = 1'b0;
    lk_addr = 28'h500;
    #1;
    total++; if (count !== 3'd4 || lk_hit !== 1'b1 || lk_mask !== 4'b0001) begin
      bad++; $display("FAIL full_accept: got count=%0d hit=%b mask=%b want 4/1/0001", count, lk_hit, lk_mask);
    end
    total++; if (dr_valid !== 1'b1 || dr_addr !== 28'h200) begin
      bad++; $display("FAIL full_next_head: got v=%b addr=%h want 1/200", dr_valid, dr_addr);
    end
  endtask

  task automatic test_head_lock();
    do_reset();
    do_write(28'h100, 2'd1, 64'h11);
    do_write(28'h200, 2'd0, 64'h22);
    tick();
    total++; if (dr_valid !== 1'b1 || dr_addr !== 28'h100) begin
      bad++; $display("FAIL lock_present: got v=%b addr=%h want 1/100", dr_valid, dr_addr);
    end
    wr_addr = 28'h100; wr_woff = 2'd2; wr_data = 64'hDD; wr_valid = 1'b1;
    #1;
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL lock_stall: got %b want 0", wr_ready); end
    tick();
    total++; if (wr_ready !== 1'b0 || dr_mask !== 4'b0010) begin
      bad++; $display("FAIL lock_stable: got rdy=%b mask=%b want 0/0010", wr_ready, dr_mask);
    end
    dr_ready = 1'b1;
    #1;
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL lock_hs_cycle: got %b want 0", wr_ready); end
    tick();
    dr_ready = 1'b0;
    #1;
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL lock_release: got %b want 1", wr_ready); end
    tick();
    wr_valid = 1'b0;
    lk_addr = 28'h100;
    #1;
    total++; if (lk_hit !== 1'b1 || lk_mask !== 4'b0100 || count !== 3'd2) begin
      bad++; $display("FAIL lock_realloc: got hit=%b mask=%b count=%0d want 1/0100/2", lk_hit, lk_mask, count);
    end
    total++; if (lk_line !== (LW'(64'hDD) << 128)) begin bad++; $display("FAIL lock_realloc_line: got %h", lk_line); end
  endtask

  task automatic test_fence();
    int drains;
    int pulses;
    do_reset();
    do_write(28'h100, 2'd0, 64'h1);
    do_write(28'h200, 2'd1, 64'h2);
    fence_valid = 1'b1;
    tick();
    fence_valid = 1'b0;
    wr_addr = 28'h300; wr_valid = 1'b1;
    #1;
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL fence_stall_miss: got %b want 0", wr_ready); end
    wr_addr = 28'h200;
    #1;
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL fence_stall_hit: got %b want 0", wr_ready); end
    wr_valid = 1'b0;
    dr_ready = 1'b1;
    drains = 0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (dr_valid) begin
        total++;
        if (dr_addr !== ((drains == 0) ? 28'h100 : 28'h200)) begin
          bad++; $display("FAIL fence_drain_order: got %h at drain %0d", dr_addr, drains);
        end
        drains++;
      end
      if (fence_ready) begin
        pulses++;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL fence_ready_count: got %0d want 0", count); end
      end
      tick();
    end
    dr_ready = 1'b0;
    total++; if (drains != 2) begin bad++; $display("FAIL fence_drains: got %0d want 2", drains); end
    total++; if (pulses != 1) begin bad++; $display("FAIL fence_pulses: got %0d want 1", pulses); end
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL fence_done_ready: got %b want 1", wr_ready); end
    fence_valid = 1'b1;
    tick();
    fence_valid = 1'b0;
    total++; if (fence_ready !== 1'b0) begin bad++; $display("FAIL fence_empty_early: got %b want 0", fence_ready); end
    tick();
    total++; if (fence_ready !== 1'b1) begin bad++; $display("FAIL fence_empty_done: got %b want 1", fence_ready); end
    tick();
    total++; if (fence_ready !== 1'b0) begin bad++; $display("FAIL fence_empty_pulse: got %b want 0", fence_ready); end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    do_write(28'h100, 2'd1, 64'hAA);
    n = 0;
    while (!dr_valid && n < 2000) begin
      tick();
      n++;
    end
`ifdef L2_WCB_TIMEOUT_EN
    total++; if (n != 1024 || dr_valid !== 1'b1) begin
      bad++; $display("FAIL timeout_rise: got cycles=%0d v=%b want 1024/1", n, dr_valid);
    end
    dr_ready = 1'b1;
    tick();
    dr_ready = 1'b0;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL timeout_drained: got %0d want 0", count); end
`else
    total++; if (n != 2000 || dr_valid !== 1'b0) begin
      bad++; $display("FAIL timeout_off: got cycles=%0d v=%b want 2000/0", n, dr_valid);
    end
`endif
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    do_write(28'h100, 2'd0, 64'h1);
    do_write(28'h200, 2'd0, 64'h2);
    tick();
    total++; if (dr_valid !== 1'b1) begin bad++; $display("FAIL rmd_pre: got %b want 1", dr_valid); end
    @(negedge clk);
    rst = 1'b0;
    lk_addr = 28'h100;
    #1;
    total++; if (dr_valid !== 1'b0 || count !== 3'd0 || lk_hit !== 1'b0) begin
      bad++; $display("FAIL rmd_async: got v=%b count=%0d hit=%b want 0/0/0", dr_valid, count, lk_hit);
    end
    tick();
    rst = 1'b1;
    mq.delete();
  endtask

  task automatic test_random();
    int wi, li, prev_size;
    bit prev_dv, prev_rdy, exp_dv, exp_rdy, wf, df;
    ent_t e;
    do_reset();
    prev_size = 0; prev_dv = 0; prev_rdy = 0;
    for (int c = 0; c < 600; c++) begin
      wr_valid = ($urandom_range(0, 99) < 60);
      wr_addr  = LA'(28'h10 + $urandom_range(0, 5));
      wr_woff  = 2'($urandom_range(0, 3));
      wr_data  = {$urandom, $urandom};
      dr_ready = ($urandom_range(0, 99) < 35);
      lk_addr  = LA'(28'h10 + $urandom_range(0, 6));
      #1;
      wi = -1; li = -1;
      foreach (mq[k]) begin
        if (mq[k].addr == wr_addr) wi = k;
        if (mq[k].addr == lk_addr) li = k;
      end
      exp_dv  = prev_dv ? !prev_rdy : ((prev_size > 0) && (prev_size >= TH));
      exp_rdy = (wi >= 0) ? !((wi == 0) && dr_valid) : (mq.size() < N);
      total++; if (count !== 3'(mq.size())) begin bad++; $display("FAIL rnd_count c%0d: got %0d want %0d", c, count, mq.size()); end
      total++; if (dr_valid !== exp_dv) begin bad++; $display("FAIL rnd_dr_valid c%0d: got %b want %b", c, dr_valid, exp_dv); end
      total++; if (wr_ready !== exp_rdy) begin bad++; $display("FAIL rnd_wr_ready c%0d: got %b want %b", c, wr_ready, exp_rdy); end
      total++;
      if (li >= 0) begin
        if (lk_hit !== 1'b1 || lk_mask !== mq[li].mask || lk_line !== mq[li].line) begin
          bad++; $display("FAIL rnd_lookup c%0d: got hit=%b mask=%b line=%h want 1/%b/%h", c, lk_hit, lk_mask, lk_line, mq[li].mask, mq[li].line);
        end
      end else if (lk_hit !== 1'b0 || lk_mask !== '0 || lk_line !== '0) begin
        bad++; $display("FAIL rnd_lookup_miss c%0d: got hit=%b mask=%b want 0/0", c, lk_hit, lk_mask);
      end
      if (dr_valid) begin
        total++;
        if (mq.size() == 0) begin
          bad++; $display("FAIL rnd_drain_empty c%0d: got addr=%h want no drain", c, dr_addr);
        end else if (dr_addr !== mq[0].addr || dr_mask !== mq[0].mask || dr_line !== mq[0].line) begin
          bad++; $display("FAIL rnd_drain c%0d: got addr=%h mask=%b want %h/%b", c, dr_addr, dr_mask, mq[0].addr, mq[0].mask);
        end
      end
      wf = wr_valid && wr_ready;
      df = dr_valid && dr_ready;
      prev_size = mq.size();
      prev_dv = dr_valid;
      prev_rdy = dr_ready;
      if (wf) begin
        if (wi >= 0) begin
          e = mq[wi];
        end else begin
          e.addr = wr_addr; e.line = '0; e.mask = '0;
        end
        e.line[int'(wr_woff)*WB +: WB] = wr_data;
        e.mask[wr_woff] = 1'b1;
        if (wi >= 0) mq[wi] = e;
        else mq.push_back(e);
      end
      if (df && mq.size() > 0) void'(mq.pop_front());
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_merge();
    test_drain();
    test_full_stall();
    test_head_lock();
    test_fence();
    test_timeout();
    test_reset_mid_drain();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
